// File: rtl/nand_nor_chk_pkg.sv
// Shared types and reference functions for the nand_nor vector checker.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package nand_nor_chk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int unsigned NUM_VECTORS = 4;

    // Reference NAND of the stimulus actually driven to the gate.
    function automatic logic exp_nand(input logic a, input logic b);
        return ~(a & b);
    endfunction

    // Reference NOR of the stimulus actually driven to the gate.
    function automatic logic exp_nor(input logic a, input logic b);
        return ~(a | b);
    endfunction

endpackage

// File: rtl/hold_timer.sv
// Down-counter that times how long each stimulus vector is held.
// Latency: expire asserts HOLD_CYCLES-1 enabled cycles after load (same cycle when HOLD_CYCLES=1).
// Backpressure: none; counts whenever enabled.
module hold_timer #(
    parameter int unsigned HOLD_CYCLES = 10,
    localparam int unsigned CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expire
);

    logic [CW-1:0] cnt;

    // Reload to HOLD_CYCLES-1 at the start of each vector, then count down to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CW'(HOLD_CYCLES - 1);
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Zero remaining means this is the last hold cycle of the current vector.
    assign expire = en && (cnt == '0);

endmodule

// File: rtl/nand_nor_vec_checker.sv
// Drives all four a/b vectors into an external nand_nor gate and scores y1/y2.
// Latency: busy for 4*HOLD_CYCLES cycles after start, then a one-cycle done pulse.
// Backpressure: none; start is ignored outside IDLE and never queued.
module nand_nor_vec_checker
    import nand_nor_chk_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a,
    output logic       b,
    input  logic       y1,
    input  logic       y2,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_vec
);

    state_t     state, state_n;
    logic [1:0] vec, vec_n, vec_inc;
    logic       a_n, b_n, busy_n, done_n, pass_n;
    logic [2:0] err_n, err_upd;
    logic [3:0] fail_n, fail_upd;
    logic       timer_load, timer_expire, sample, mismatch;

    hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_hold_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (timer_load),
        .en     (state == DRIVE),
        .expire (timer_expire)
    );

    // Score against the registered stimulus, so the check sees exactly what the gate sees.
    assign sample   = timer_expire;
    assign mismatch = (y1 != exp_nand(a, b)) || (y2 != exp_nor(a, b));
    assign err_upd  = err_count + {2'b00, mismatch};
    assign fail_upd = fail_vec | (mismatch ? (4'b0001 << vec) : 4'b0000);
    assign vec_inc  = vec + 2'd1;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state, stimulus and scoreboard updates.
    always_comb begin
        state_n    = state;
        vec_n      = vec;
        a_n        = a;
        b_n        = b;
        busy_n     = busy;
        done_n     = 1'b0;
        pass_n     = pass;
        err_n      = err_count;
        fail_n     = fail_vec;
        timer_load = 1'b0;
        case (state)
            IDLE: begin
                a_n    = 1'b0;
                b_n    = 1'b0;
                busy_n = 1'b0;
                if (start) begin
                    state_n    = DRIVE;
                    vec_n      = 2'd0;
                    timer_load = 1'b1;
                    busy_n     = 1'b1;
                    pass_n     = 1'b0;
                    err_n      = '0;
                    fail_n     = '0;
                end
            end
            DRIVE: begin
                if (sample) begin
                    err_n  = err_upd;
                    fail_n = fail_upd;
                    if (vec == 2'(NUM_VECTORS - 1)) begin
                        state_n = DONE;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        a_n     = 1'b0;
                        b_n     = 1'b0;
                        pass_n  = (err_upd == '0);
                    end else begin
                        vec_n      = vec_inc;
                        a_n        = vec_inc[1];
                        b_n        = vec_inc[0];
                        timer_load = 1'b1;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Registered outputs and vector index; reset clears results.
    always_ff @(posedge clk) begin
        if (rst) begin
            vec       <= 2'd0;
            a         <= 1'b0;
            b         <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_vec  <= '0;
        end else begin
            vec       <= vec_n;
            a         <= a_n;
            b         <= b_n;
            busy      <= busy_n;
            done      <= done_n;
            pass      <= pass_n;
            err_count <= err_n;
            fail_vec  <= fail_n;
        end
    end

endmodule

// File: doc/nand_nor_vec_checker.md
# nand_nor_vec_checker

Self-checking stimulus and response stage wrapped around the `nand_nor` gate. On `start` it drives `a`/`b` through all four input vectors (00, 01, 10, 11) and holds each for a programmable number of cycles. On the last hold cycle of each vector it samples `y1`/`y2` and compares them against NAND/NOR expectations. Results are reported as a pass flag, an error count and a per-vector fail bitmap, closed by a one-cycle `done` pulse.

## Interface
- `HOLD_CYCLES`, default 10: cycles each vector is driven; legal range ≥1.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset; **synchronous, active-high**.
- `start`  in  1  run request; sampled only in IDLE.
- `a`  out  1  registered stimulus to the `nand_nor` input `a`.
- `b`  out  1  registered stimulus to the `nand_nor` input `b`.
- `y1`  in  1  `nand_nor` NAND output.
- `y2`  in  1  `nand_nor` NOR output.
- `busy`  out  1  high while vectors are being driven.
- `done`  out  1  one-cycle pulse when the run completes.
- `pass`  out  1  high when the last completed run had zero mismatches.
- `err_count`  out  3  number of failing vectors in the last run (0–4).
- `fail_vec`  out  4  bit i set when vector i ({a,b} = i) failed.

## Operation
- **FSM states:** IDLE, DRIVE, DONE.
- **Reset values:** all outputs are 0 (`a`, `b`, `busy`, `done`, `pass`, `err_count`, `fail_vec`); state = IDLE; `vec` = 0; `hold_cnt` = 0.
- **IDLE:** `a` = `b` = 0. When `start` = 1, go to DRIVE, set `vec` = 0, set `hold_cnt` = 0, and clear `pass`, `err_count` and `fail_vec`.
- **DRIVE:**
  - `a` = `vec[1]`, `b` = `vec[0]`, `busy` = 1.
  - `hold_cnt` increments each cycle.
  - When `hold_cnt` == HOLD_CYCLES−1, compare `y1` against ~(a&b) and `y2` against ~(a|b).
  - On a mismatch in either output, set `fail_vec[vec]` and increment `err_count` by 1. Each vector counts at most once.
  - Then, if `vec` == 3, go to DONE; otherwise increment `vec` and reset `hold_cnt` to 0.
- **DONE:**
  - `done` = 1 for exactly one cycle.
  - `pass` = (`err_count` == 0), counting any mismatch on the final vector.
  - `busy` = 0, `a` = `b` = 0, then return to IDLE.
- **Result hold:** `pass`, `err_count` and `fail_vec` hold until the next accepted `start` or `rst`.
- **Boundary conditions:**
  - `start` asserted during DRIVE or DONE is ignored; it is not queued.
  - `start` held high continuously causes back-to-back runs, with one IDLE cycle between `done` and the next DRIVE.
  - `rst` mid-run aborts immediately: no `done`, results cleared to reset values.
  - `err_count` cannot overflow, since the maximum is 4.
  - Expected-value comparison uses the registered `a`/`b`, not `vec`.

## Timing
- `start` is sampled high at edge k. `a`/`b` show vector 0 from edge k+1.
- Vector i is driven for cycles k+1+i·H through k+i·H+H, where H = HOLD_CYCLES. Its sample is taken on the last of those cycles.
- `done` is high during cycle k+1+4H. Results are valid from that cycle.
- `busy` is high for exactly 4H cycles.
- `nand_nor` is purely combinational, so H=1 is legal: the sample is taken in the same cycle the vector is applied.

## Structure
- **Package `nand_nor_chk_pkg`:**
  - state enum (IDLE/DRIVE/DONE);
  - `NUM_VECTORS` = 4;
  - functions `exp_nand(a,b)` and `exp_nor(a,b)`.
- **Sub-module `hold_timer`:** parameterised down-counter with `load`/`expire` outputs. The FSM, vector register and scoreboard stay in the top module.
- **Instantiation:** `nand_nor` is instantiated alongside this block, not inside it.

## Test plan
- **Correct gate, H=10:** connect a real `nand_nor` and pulse `start` → `busy` for 40 cycles, `done` at cycle 41, `pass`=1, `err_count`=0, `fail_vec`=4'b0000.
- **`y1` stuck at 0:** → `pass`=0, `err_count`=3, `fail_vec`=4'b0111.
- **`y2` stuck at 1:** → `pass`=0, `err_count`=3, `fail_vec`=4'b1110.
- **`y1`/`y2` swapped:** → vectors 0 and 3 pass and vectors 1 and 2 fail, giving `fail_vec`=4'b0110 and `err_count`=2.
- **Reset mid-run:** assert `rst` at cycle 15 of a run → next cycle all outputs are 0, no `done` pulse. A following `start` completes a normal run.
- **H=1 with `start` held high:** `done` every 6 cycles (4 DRIVE, 1 DONE, 1 IDLE), `pass`=1 each run. `start` pulses during `busy` have no effect.
